dac_serializer: RTL and testbench

Transmit-side counterpart of the ADC receive path: accepts parallel signed 16-bit left/right samples and serializes them onto the codec-style serial bus (BCLK, LRCK, WCLK, serialOut), MSB first. The block is the bus master and generates all bus clocks from clk. It sits between the channel-strip processing output and the DAC pins, with a one-deep sample buffer and a valid/ready input handshake.

---
 rtl/dac_serializer.sv | 162 ++++++++++++++++
 tb/tb_dac_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serializer.sv
// dac_serializer: parallel stereo samples to codec-style serial bus (BCLK/LRCK/WCLK/serialOut).
// Bus master. A one-deep sample buffer with a valid/ready handshake feeds a per-frame latch
// that fires on the left-slot-1 BCLK fall edge.
module dac_serializer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SLOTS      = 32,
    parameter int unsigned CLK_DIV    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] leftIn,
    input  logic [DATA_WIDTH-1:0] rightIn,
    input  logic                  inValid,
    output logic                  inReady,
    output logic                  BCLK,
    output logic                  LRCK,
    output logic                  WCLK,
    output logic                  serialOut,
    output logic                  underrun
);

    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SlotW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned IdxW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DivW-1:0]  DivMax   = DivW'(CLK_DIV - 1);
    localparam logic [SlotW-1:0] SlotMax  = SlotW'(SLOTS - 1);
    localparam logic [SlotW-1:0] DataLast = SlotW'(DATA_WIDTH);

    logic [DivW-1:0]       div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic                  lrck_q, lrck_d;
    logic                  wclk_q, wclk_d;
    logic                  sout_q, sout_d;
    logic                  underrun_q, underrun_d;
    logic [SlotW-1:0]      slot_q, slot_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DATA_WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
    logic [DATA_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;

    logic             div_wrap;
    logic             fall;
    logic             slot_wrap;
    logic [SlotW-1:0] slot_nxt;
    logic             lrck_nxt;
    logic             latch;
    logic             capture;
    logic [SlotW-1:0] bit_diff;
    logic [IdxW-1:0]  bit_idx;

    // Event decode: divider wrap, BCLK fall edge, frame latch point and input capture.
    always_comb begin
        div_wrap  = (div_q == DivMax);
        fall      = div_wrap & bclk_q;
        slot_wrap = (slot_q == SlotMax);
        slot_nxt  = slot_wrap ? '0 : slot_q + SlotW'(1);
        lrck_nxt  = slot_wrap ? ~lrck_q : lrck_q;
        // Entering left slot 1: current slot 0 of the left half, no LRCK toggle on this edge.
        latch     = fall & lrck_q & (slot_q == '0);
        capture   = inValid & ~buf_full_q;
        bit_diff  = DataLast - slot_nxt;
        bit_idx   = bit_diff[IdxW-1:0];
    end

    // Next-state: divider, buffer handshake, frame latch and bus outputs on BCLK fall edges.
    always_comb begin
        div_d      = div_wrap ? '0 : div_q + DivW'(1);
        bclk_d     = div_wrap ? ~bclk_q : bclk_q;
        lrck_d     = lrck_q;
        wclk_d     = wclk_q;
        sout_d     = sout_q;
        slot_d     = slot_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        last_l_d   = last_l_q;
        last_r_d   = last_r_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        underrun_d = latch & ~buf_full_q;

        if (capture) begin
            buf_full_d = 1'b1;
            buf_l_d    = leftIn;
            buf_r_d    = rightIn;
        end

        // A capture on the latch clk only happens with the buffer empty, so it survives here.
        if (latch) begin
            if (buf_full_q) begin
                sh_l_d     = buf_l_q;
                sh_r_d     = buf_r_q;
                last_l_d   = buf_l_q;
                last_r_d   = buf_r_q;
                buf_full_d = 1'b0;
            end else begin
                sh_l_d = last_l_q;
                sh_r_d = last_r_q;
            end
        end

        // Shift registers are read via their _d value so left slot 1 sees the fresh latch.
        if (fall) begin
            slot_d = slot_nxt;
            lrck_d = lrck_nxt;
            if ((slot_nxt != '0) && (slot_nxt <= DataLast)) begin
                wclk_d = 1'b1;
                sout_d = lrck_nxt ? sh_l_d[bit_idx] : sh_r_d[bit_idx];
            end else begin
                wclk_d = 1'b0;
                sout_d = 1'b0;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b1;
            wclk_q     <= 1'b0;
            sout_q     <= 1'b0;
            underrun_q <= 1'b0;
            slot_q     <= '0;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            last_l_q   <= '0;
            last_r_q   <= '0;
            sh_l_q     <= '0;
            sh_r_q     <= '0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            wclk_q     <= wclk_d;
            sout_q     <= sout_d;
            underrun_q <= underrun_d;
            slot_q     <= slot_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            last_l_q   <= last_l_d;
            last_r_q   <= last_r_d;
            sh_l_q     <= sh_l_d;
            sh_r_q     <= sh_r_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        inReady   = ~buf_full_q;
        BCLK      = bclk_q;
        LRCK      = lrck_q;
        WCLK      = wclk_q;
        serialOut = sout_q;
        underrun  = underrun_q;
    end

endmodule

// File: tb/tb_dac_serializer.sv
// Bench for dac_serializer: two instances (CLK_DIV=1 and CLK_DIV=3), a bus monitor that
// reassembles words from the serial line, and a per-instance scoreboard of expected frames.
module tb_dac_serializer;

    localparam int SLOTS = 32;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, v0, v1;
    logic [15:0] l0, r0, l1, r1;
    logic        rdy0, bclk0, lrck0, wclk0, sout0, und0;
    logic        rdy1, bclk1, lrck1, wclk1, sout1, und1;

    dac_serializer #(.DATA_WIDTH(16), .SLOTS(SLOTS), .CLK_DIV(1)) dut0 (
        .clk(clk), .reset(rst0), .leftIn(l0), .rightIn(r0), .inValid(v0), .inReady(rdy0),
        .BCLK(bclk0), .LRCK(lrck0), .WCLK(wclk0), .serialOut(sout0), .underrun(und0)
    );

    dac_serializer #(.DATA_WIDTH(16), .SLOTS(SLOTS), .CLK_DIV(3)) dut1 (
        .clk(clk), .reset(rst1), .leftIn(l1), .rightIn(r1), .inValid(v1), .inReady(rdy1),
        .BCLK(bclk1), .LRCK(lrck1), .WCLK(wclk1), .serialOut(sout1), .underrun(und1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    frame_t q0[$];
    frame_t q1[$];

    // Monitor state, indexed by instance.
    logic        p_bclk[2], p_wclk[2], p_sout[2], p_lrck[2], p_rst[2];
    logic [15:0] word[2];
    int          nbits[2], und_len[2], cyc[2], last_rise[2], last_lr[2], viol[2];
    bit          und_seen[2], rise_known[2], lr_known[2], pend_v[2];
    frame_t      pend[2];
    int          frames_done[2], words_done[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic frame_t mk(input logic [15:0] l, input logic [15:0] r, input logic u);
        frame_t f;
        f.l = l;
        f.r = r;
        f.und = u;
        return f;
    endfunction

    task automatic mon(input int d, input int div, input logic rst, input logic bclk,
                       input logic lrck, input logic wclk, input logic sout, input logic und);
        frame_t e;
        cyc[d]++;
        if (rst || p_rst[d]) begin
            nbits[d] = 0; und_len[d] = 0; und_seen[d] = 0;
            rise_known[d] = 0; lr_known[d] = 0; pend_v[d] = 0;
        end else begin
            if (und) begin
                und_len[d]++;
                und_seen[d] = 1;
            end else if (und_len[d] > 0) begin
                check("underrun_width", und_len[d], 1);
                und_len[d] = 0;
            end
            // Bus outputs may only move on a BCLK fall edge; idle serial line must be 0.
            if ((wclk != p_wclk[d] || sout != p_sout[d] || lrck != p_lrck[d]) &&
                !(p_bclk[d] && !bclk)) viol[d]++;
            if (!wclk && sout) viol[d]++;
            if (!p_bclk[d] && bclk) begin
                if (rise_known[d] && (cyc[d] - last_rise[d] != 2 * div)) viol[d]++;
                last_rise[d] = cyc[d];
                rise_known[d] = 1;
                if (wclk) begin
                    word[d] = {word[d][14:0], sout};
                    nbits[d]++;
                end
            end
            if (lrck != p_lrck[d]) begin
                if (lr_known[d]) check("lrck_half_period", cyc[d] - last_lr[d], SLOTS * 2 * div);
                last_lr[d] = cyc[d];
                lr_known[d] = 1;
            end
            if (p_wclk[d] && !wclk) begin
                words_done[d]++;
                check("word_bits", nbits[d], 16);
                if (lrck) begin
                    frames_done[d]++;
                    if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check("left_word", word[d], e.l);
                        check("underrun_seen", und_seen[d], e.und);
                        pend[d] = e;
                        pend_v[d] = 1;
                    end
                    und_seen[d] = 0;
                end else if (pend_v[d]) begin
                    check("right_word", word[d], pend[d].r);
                    pend_v[d] = 0;
                end
                nbits[d] = 0;
            end
        end
        p_rst[d] = rst; p_bclk[d] = bclk; p_wclk[d] = wclk; p_sout[d] = sout; p_lrck[d] = lrck;
    endtask

    always @(negedge clk) begin
        mon(0, 1, rst0, bclk0, lrck0, wclk0, sout0, und0);
        mon(1, 3, rst1, bclk1, lrck1, wclk1, sout1, und1);
    end

    task automatic wait_frames(input int d, input int n, input int budget);
        for (int i = 0; i < budget && frames_done[d] < n; i++) @(negedge clk);
        if (frames_done[d] < n) check("timeout_frames", frames_done[d], n);
    endtask

    task automatic wait_words(input int d, input int n, input int budget);
        for (int i = 0; i < budget && words_done[d] < n; i++) @(negedge clk);
        if (words_done[d] < n) check("timeout_words", words_done[d], n);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            p_bclk[d] = 0; p_wclk[d] = 0; p_sout[d] = 0; p_lrck[d] = 1; p_rst[d] = 1;
            word[d] = '0; nbits[d] = 0; und_len[d] = 0; cyc[d] = 0; last_rise[d] = 0;
            last_lr[d] = 0; viol[d] = 0; und_seen[d] = 0; rise_known[d] = 0;
            lr_known[d] = 0; pend_v[d] = 0; pend[d] = '0; frames_done[d] = 0; words_done[d] = 0;
        end
        rst0 = 1; rst1 = 1; v0 = 0; v1 = 0; l0 = '0; r0 = '0; l1 = '0; r1 = '0;
        fork
            begin : div1_path
                int   got;
                int   falls;
                logic pb;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("rst_bclk", bclk0, 0);
                check("rst_lrck", lrck0, 1);
                check("rst_wclk", wclk0, 0);
                check("rst_sout", sout0, 0);
                check("rst_underrun", und0, 0);
                check("rst_ready", rdy0, 1);
                @(posedge clk); #1;
                rst0 = 0; l0 = 16'h0009; r0 = 16'h0006; v0 = 1;
                q0.push_back(mk(16'h0009, 16'h0006, 1'b0));
                @(negedge clk); check("ready_before_cap", rdy0, 1);
                @(posedge clk); #1; v0 = 0;
                @(negedge clk); check("ready_after_cap", rdy0, 0);
                @(negedge clk); check("ready_after_latch", rdy0, 1);
                q0.push_back(mk(16'h0009, 16'h0006, 1'b1));
                wait_frames(0, 2, 400);
                @(posedge clk); #1;
                l0 = 16'h1234; r0 = 16'h5678; v0 = 1;
                q0.push_back(mk(16'h1234, 16'h5678, 1'b0));
                @(posedge clk); #1;
                l0 = 16'h8000; r0 = 16'h7FFF;
                q0.push_back(mk(16'h8000, 16'h7FFF, 1'b0));
                @(negedge clk); check("ready_full", rdy0, 0);
                got = 0;
                for (int i = 0; i < 300 && got == 0; i++) begin
                    @(negedge clk);
                    if (rdy0) got = 1;
                end
                check("backpressure_release", got, 1);
                @(posedge clk); #1; v0 = 0;
                @(negedge clk); check("ready_recapture", rdy0, 0);
                q0.push_back(mk(16'h8000, 16'h7FFF, 1'b1));
                wait_frames(0, 5, 600);
                got = 0;
                for (int i = 0; i < 200 && got == 0; i++) begin
                    @(negedge clk);
                    if (!lrck0) got = 1;
                end
                check("reach_right_half", got, 1);
                falls = 0;
                pb = bclk0;
                for (int i = 0; i < 100 && falls < 10; i++) begin
                    @(negedge clk);
                    if (pb && !bclk0) falls++;
                    pb = bclk0;
                end
                check("reach_right_slot10", falls, 10);
                @(posedge clk); #1; rst0 = 1;
                @(posedge clk);
                @(negedge clk);
                check("midrst_bclk", bclk0, 0);
                check("midrst_lrck", lrck0, 1);
                check("midrst_wclk", wclk0, 0);
                check("midrst_sout", sout0, 0);
                check("midrst_ready", rdy0, 1);
                #1; rst0 = 0;
                q0.push_back(mk(16'h0000, 16'h0000, 1'b1));
                q0.push_back(mk(16'h0000, 16'h0000, 1'b1));
                wait_words(0, 13, 800);
            end
            begin : div3_path
                repeat (3) @(posedge clk); #1;
                rst1 = 0; l1 = 16'h0009; r1 = 16'h0006; v1 = 1;
                q1.push_back(mk(16'h0009, 16'h0006, 1'b0));
                @(posedge clk); #1; v1 = 0;
                q1.push_back(mk(16'h0009, 16'h0006, 1'b1));
                wait_words(1, 4, 1200);
            end
        join
        repeat (4) @(negedge clk);
        check("bus_timing_viol_div1", viol[0], 0);
        check("bus_timing_viol_div3", viol[1], 0);
        check("sb_drained_div1", q0.size(), 0);
        check("sb_drained_div3", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
